// File: rtl/seg7_scan_drv.sv
// rtl/seg7_scan_drv.sv - eight-digit multiplexed seven-segment scan driver
// Frame-snapshot shadows keep a digit set coherent across one full scan.
module seg7_scan_drv #(
   parameter int SCAN_CNT     = 100000,
   parameter int BLINK_FRAMES = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        EN,
   input  logic [31:0] Disp_num,
   input  logic [7:0]  point_in,
   input  logic [7:0]  blink_in,
   output logic [7:0]  AN,
   output logic [7:0]  SEGMENT,
   output logic        frame_sync
);

   localparam int PW = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [PW-1:0] pcnt_q, pcnt_d;
   logic [2:0]    dig_q, dig_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic          blink_q, blink_d;
   logic          load_pend_q;
   logic [31:0]   num_q;
   logic [7:0]    pt_q, bl_q;
   logic [7:0]    an_q, an_d, seg_q, seg_d;
   logic          fsync_q;

   logic          tick, wrap, load;
   logic [31:0]   num_eff;
   logic [7:0]    pt_eff, bl_eff;
   logic [3:0]    nib;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h40;
         4'h1: hex7 = 7'h79;
         4'h2: hex7 = 7'h24;
         4'h3: hex7 = 7'h30;
         4'h4: hex7 = 7'h19;
         4'h5: hex7 = 7'h12;
         4'h6: hex7 = 7'h02;
         4'h7: hex7 = 7'h78;
         4'h8: hex7 = 7'h00;
         4'h9: hex7 = 7'h10;
         4'hA: hex7 = 7'h08;
         4'hB: hex7 = 7'h03;
         4'hC: hex7 = 7'h46;
         4'hD: hex7 = 7'h21;
         4'hE: hex7 = 7'h06;
         default: hex7 = 7'h0E;
      endcase
   endfunction

   assign tick = (pcnt_q == PW'(SCAN_CNT - 1));
   assign wrap = tick && (dig_q == 3'd7);
   assign load = wrap || load_pend_q;

   // The post-reset load coincides with digit 0, so that digit shows the fresh inputs.
   assign num_eff = load_pend_q ? Disp_num : num_q;
   assign pt_eff  = load_pend_q ? point_in : pt_q;
   assign bl_eff  = load_pend_q ? blink_in : bl_q;
   assign nib     = num_eff[{dig_q, 2'b00} +: 4];

   always_comb begin
      pcnt_d  = tick ? '0 : pcnt_q + PW'(1);
      dig_d   = tick ? dig_q + 3'd1 : dig_q;
      fcnt_d  = fcnt_q;
      blink_d = blink_q;
      if (wrap) begin
         if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
            fcnt_d  = '0;
            blink_d = ~blink_q;
         end else begin
            fcnt_d = fcnt_q + FW'(1);
         end
      end

      an_d = ~(8'd1 << dig_q);
      if (!EN || (blink_q && bl_eff[dig_q]))
         an_d = 8'hFF;

      seg_d = {~pt_eff[dig_q], hex7(nib)};
      if (!EN)
         seg_d = 8'hFF;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt_q      <= '0;
         dig_q       <= 3'd0;
         fcnt_q      <= '0;
         blink_q     <= 1'b0;
         load_pend_q <= 1'b1;
         num_q       <= 32'd0;
         pt_q        <= 8'd0;
         bl_q        <= 8'd0;
         an_q        <= 8'hFF;
         seg_q       <= 8'hFF;
         fsync_q     <= 1'b0;
      end else begin
         pcnt_q      <= pcnt_d;
         dig_q       <= dig_d;
         fcnt_q      <= fcnt_d;
         blink_q     <= blink_d;
         load_pend_q <= 1'b0;
         if (load) begin
            num_q <= Disp_num;
            pt_q  <= point_in;
            bl_q  <= blink_in;
         end
         an_q    <= an_d;
         seg_q   <= seg_d;
         fsync_q <= load;
      end
   end

   assign AN         = an_q;
   assign SEGMENT    = seg_q;
   assign frame_sync = fsync_q;

endmodule

// File: tb/tb_seg7_scan_drv.sv
// tb/tb_seg7_scan_drv.sv - self-checking bench for seg7_scan_drv
module tb_seg7_scan_drv;

   localparam int SCAN = 4;
   localparam int BF   = 2;

   localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   logic        clk = 1'b0;
   logic        rst, EN;
   logic [31:0] Disp_num;
   logic [7:0]  point_in, blink_in;
   logic [7:0]  AN, SEGMENT;
   logic        frame_sync;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [7:0] an;
      logic [7:0] seg;
      logic       fs;
   } exp_t;

   typedef struct {
      logic [31:0] disp;
      logic [7:0]  pt;
      logic [7:0]  bl;
      logic        en;
      logic [7:0]  an0, seg0, an1, seg1;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[8];

   seg7_scan_drv #(.SCAN_CNT(SCAN), .BLINK_FRAMES(BF)) dut (
      .clk(clk), .rst(rst), .EN(EN), .Disp_num(Disp_num),
      .point_in(point_in), .blink_in(blink_in),
      .AN(AN), .SEGMENT(SEGMENT), .frame_sync(frame_sync)
   );

   always #5 clk = ~clk;

   // reference model state
   int          m_pcnt, m_dig, m_fcnt;
   logic        m_blink, m_lp;
   logic [31:0] m_d;
   logic [7:0]  m_p, m_b;

   function automatic exp_t model_out(logic r, logic en, logic lp, int pc, int dg, logic bk,
                                      logic [31:0] d, logic [7:0] p, logic [7:0] b);
      exp_t e;
      if (r) begin
         e.an = 8'hFF; e.seg = 8'hFF; e.fs = 1'b0;
         return e;
      end
      e.fs = lp || (pc == SCAN - 1 && dg == 7);
      if (!en) begin
         e.an = 8'hFF; e.seg = 8'hFF;
      end else begin
         e.an  = (bk && b[dg]) ? 8'hFF : ~(8'h01 << dg);
         e.seg = {~p[dg], HEX[d[4*dg +: 4]]};
      end
      return e;
   endfunction

   always @(posedge clk) begin
      sb.push_back(model_out(rst, EN, m_lp, m_pcnt, m_dig, m_blink,
                             m_lp ? Disp_num : m_d, m_lp ? point_in : m_p, m_lp ? blink_in : m_b));
      if (rst) begin
         m_pcnt <= 0; m_dig <= 0; m_fcnt <= 0; m_blink <= 1'b0; m_lp <= 1'b1;
         m_d <= '0; m_p <= '0; m_b <= '0;
      end else begin
         m_lp <= 1'b0;
         if (m_lp || (m_pcnt == SCAN - 1 && m_dig == 7)) begin
            m_d <= Disp_num; m_p <= point_in; m_b <= blink_in;
         end
         if (m_pcnt == SCAN - 1) begin
            m_pcnt <= 0;
            m_dig  <= (m_dig + 1) % 8;
            if (m_dig == 7) begin
               if (m_fcnt == BF - 1) begin
                  m_fcnt  <= 0;
                  m_blink <= ~m_blink;
               end else begin
                  m_fcnt <= m_fcnt + 1;
               end
            end
         end else begin
            m_pcnt <= m_pcnt + 1;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic nxt();
      exp_t e;
      @(negedge clk);
      if (sb.size() == 0) begin
         chk("sb_empty", 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk("sb_an", AN, e.an);
         chk("sb_seg", SEGMENT, e.seg);
         chk("sb_fs", frame_sync, e.fs);
      end
   endtask

   task automatic run_frame(input string tag, input logic [63:0] an_e, input logic [63:0] seg_e,
                            input logic fs0, input logic mid);
      for (int d = 0; d < 8; d++) begin
         for (int c = 0; c < 4; c++) begin
            nxt();
            chk({tag, "_an"}, AN, an_e[8*d +: 8]);
            chk({tag, "_seg"}, SEGMENT, seg_e[8*d +: 8]);
            if (d == 0 && c == 0) chk({tag, "_fs0"}, frame_sync, fs0);
            if (d == 7 && c == 3) chk({tag, "_fs_end"}, frame_sync, 1'b1);
            if (mid && d == 3 && c == 0) Disp_num = 32'h12345678;
         end
      end
   endtask

   initial begin
      int w;
      tbl[0] = '{32'h000000A0, 8'h02, 8'h01, 1'b1, 8'hFF, 8'hC0, 8'hFD, 8'h08};
      tbl[1] = '{32'h000000B9, 8'h01, 8'h02, 1'b1, 8'hFE, 8'h10, 8'hFF, 8'h83};
      tbl[2] = '{32'h000000DC, 8'h00, 8'hFF, 1'b1, 8'hFE, 8'hC6, 8'hFD, 8'hA1};
      tbl[3] = '{32'h0000007E, 8'h03, 8'h00, 1'b1, 8'hFE, 8'h06, 8'hFD, 8'h78};
      tbl[4] = '{32'h00000065, 8'h00, 8'h00, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      tbl[5] = '{32'h00000034, 8'h00, 8'h03, 1'b1, 8'hFF, 8'h99, 8'hFF, 8'hB0};
      tbl[6] = '{32'h00000021, 8'h00, 8'h03, 1'b1, 8'hFE, 8'hF9, 8'hFD, 8'hA4};
      tbl[7] = '{32'h00000056, 8'h01, 8'h00, 1'b1, 8'hFE, 8'h02, 8'hFD, 8'h92};

      rst = 1'b1; EN = 1'b1; Disp_num = '0; point_in = '0; blink_in = '0;
      for (int i = 0; i < 3; i++) begin
         nxt();
         chk("rst_an", AN, 8'hFF);
         chk("rst_seg", SEGMENT, 8'hFF);
         chk("rst_fs", frame_sync, 1'b0);
      end

      Disp_num = 32'h000000FF;
      rst = 1'b0;
      run_frame("f0", 64'h7FBFDFEFF7FBFDFE, 64'hC0C0C0C0C0C08E8E, 1'b1, 1'b1);
      Disp_num = 32'h000000FF; point_in = 8'h01; blink_in = 8'h02;
      run_frame("f1", 64'h7FBFDFEFF7FBFDFE, 64'hF9A4B0999282F880, 1'b0, 1'b0);
      run_frame("f2", 64'h7FBFDFEFF7FBFFFE, 64'hC0C0C0C0C0C08E0E, 1'b0, 1'b0);
      run_frame("f3", 64'h7FBFDFEFF7FBFFFE, 64'hC0C0C0C0C0C08E0E, 1'b0, 1'b0);
      run_frame("f4", 64'h7FBFDFEFF7FBFDFE, 64'hC0C0C0C0C0C08E0E, 1'b0, 1'b0);

      for (int i = 0; i < 8; i++) begin
         Disp_num = tbl[i].disp; point_in = tbl[i].pt; blink_in = tbl[i].bl; EN = tbl[i].en;
         w = 0;
         do begin
            nxt();
            w++;
         end while (frame_sync !== 1'b1 && w < 40);
         chk("tbl_sync_gap", w, (i == 0) ? 32 : 27);
         nxt();
         chk("tbl_an0", AN, tbl[i].an0);
         chk("tbl_seg0", SEGMENT, tbl[i].seg0);
         repeat (3) nxt();
         nxt();
         chk("tbl_an1", AN, tbl[i].an1);
         chk("tbl_seg1", SEGMENT, tbl[i].seg1);
      end

      repeat (16) nxt();
      rst = 1'b1;
      nxt();
      chk("mid_rst_an", AN, 8'hFF);
      chk("mid_rst_seg", SEGMENT, 8'hFF);
      chk("mid_rst_fs", frame_sync, 1'b0);
      rst = 1'b0; Disp_num = 32'h000000A7; point_in = 8'h00; blink_in = 8'h01;
      nxt();
      chk("restart_fs", frame_sync, 1'b1);
      chk("restart_an0", AN, 8'hFE);
      chk("restart_seg0", SEGMENT, 8'hF8);
      repeat (3) nxt();
      nxt();
      chk("restart_an1", AN, 8'hFD);
      chk("restart_seg1", SEGMENT, 8'h88);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
